// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit timing.
// The PAR state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned BAUD_W               = 16;
    localparam int unsigned BIT_W                = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PAR   = 3'd3,
`endif
        S_STOP  = 3'd4
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and a sticky overflow flag.
// Pushes are qualified by the pre-edge full flag; a dropped push leaves contents unchanged.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, drop;

    always_comb begin
        push     = wr_en_i && !full_q;
        drop     = wr_en_i && full_q;
        pop      = rd_en_i && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
        // A dropped write wins over a simultaneous clear
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_c  = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_tx_responder.sv
// FIFO-buffered UART transmitter: 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
// The serial line register follows the FSM state by one cycle, so it falls two edges after a write.
module uart_tx_responder
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       uart_rxd_out
);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 pop;
    logic                 bit_end;
    logic                 last_bit;
    logic [DATA_BITS-1:0] fifo_rd_data_c;
    logic                 fifo_full, fifo_empty, fifo_ovf;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i      (CLK100MHZ),
        .rst_i      (reset),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (pop),
        .clr_ovf_i  (clr_ovf),
        .rd_data_c  (fifo_rd_data_c),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    // Next-state, counters, shift register and line value
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        bit_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        last_bit = (bit_q == BIT_W'(DATA_BITS - 1));
        baud_d   = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data_c;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_rd_data_c);
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (last_bit) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more bytes are queued
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data_c;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_rd_data_c);
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PAR:   tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign full         = fifo_full;
    assign empty        = fifo_empty;
    assign overflow     = fifo_ovf;
    assign busy         = busy_q;
    assign uart_rxd_out = tx_q;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed bench for uart_tx_responder with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_responder;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full, empty, busy, overflow, tx;

    int total = 0;
    int bad   = 0;

    uart_tx_responder #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .CLK100MHZ    (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_ovf      (clr_ovf),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .overflow     (overflow),
        .uart_rxd_out (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        clr_ovf = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Checks one frame sample per cycle; sample 0 is the first cycle the start bit is on the line
    task automatic expect_frame(input logic [7:0] b, input int skip, input logic last_busy);
        logic [10:0] bits;
        int nb;
        nb = PAR_EN ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
        if (PAR_EN) bits[9] = ^b;
        for (int s = skip; s < nb * 4; s++) begin
            chk($sformatf("line_%02h_s%0d", b, s), {31'd0, tx}, {31'd0, bits[s/4]});
            chk($sformatf("busy_%02h_s%0d", b, s), {31'd0, busy},
                {31'd0, (s == nb * 4 - 1) ? last_busy : 1'b1});
            step();
        end
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;

        // Asynchronous reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_line", {31'd0, tx}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        step();
        reset = 1'b0;

        // Single byte 0x55: line falls two edges after the accepting edge
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        chk("t1_empty_after_wr", {31'd0, empty}, 32'd0);
        chk("t1_busy_e0", {31'd0, busy}, 32'd0);
        chk("t1_line_e0", {31'd0, tx}, 32'd1);
        step();
        chk("t1_busy_e1", {31'd0, busy}, 32'd1);
        chk("t1_line_e1", {31'd0, tx}, 32'd1);
        chk("t1_empty_e1", {31'd0, empty}, 32'd1);
        step();
        expect_frame(8'h55, 0, 1'b0);
        chk("t1_idle_line", {31'd0, tx}, 32'd1);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Four back-to-back frames
        do_reset();
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        chk("t2_line_e0", {31'd0, tx}, 32'd1);
        wr_data = 8'h3C;
        step();
        chk("t2_line_e1", {31'd0, tx}, 32'd1);
        wr_data = 8'hFF;
        step();
        chk("t2_line_e2", {31'd0, tx}, 32'd0);
        wr_data = 8'h00;
        step();
        wr_en = 1'b0;
        chk("t2_full_e3", {31'd0, full}, 32'd0);
        expect_frame(8'hA5, 1, 1'b1);
        expect_frame(8'h3C, 0, 1'b1);
        expect_frame(8'hFF, 0, 1'b1);
        expect_frame(8'h00, 0, 1'b0);
        chk("t2_empty_end", {31'd0, empty}, 32'd1);
        chk("t2_line_end", {31'd0, tx}, 32'd1);

        // Fill, overflow, clear coinciding with drop, then clear
        do_reset();
        wr_en = 1'b1; wr_data = 8'h11;
        step();
        wr_data = 8'h22;
        step();
        wr_data = 8'h33;
        step();
        chk("t3_line_e2", {31'd0, tx}, 32'd0);
        wr_data = 8'h44;
        step();
        chk("t3_full_e3", {31'd0, full}, 32'd0);
        wr_data = 8'h55;
        step();
        chk("t3_full_e4", {31'd0, full}, 32'd1);
        chk("t3_ovf_e4", {31'd0, overflow}, 32'd0);
        wr_data = 8'h66;
        step();
        chk("t3_ovf_e5", {31'd0, overflow}, 32'd1);
        chk("t3_full_e5", {31'd0, full}, 32'd1);
        wr_data = 8'h77; clr_ovf = 1'b1;
        step();
        chk("t3_ovf_clr_with_drop", {31'd0, overflow}, 32'd1);
        wr_en = 1'b0;
        step();
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
        expect_frame(8'h11, 5, 1'b1);
        expect_frame(8'h22, 0, 1'b1);
        expect_frame(8'h33, 0, 1'b1);
        expect_frame(8'h44, 0, 1'b1);
        expect_frame(8'h55, 0, 1'b0);
        chk("t3_empty_end", {31'd0, empty}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t3_no_dropped_frame", {31'd0, tx}, 32'd1);
            step();
        end

        // Reset mid DATA bit 2 with two bytes queued
        do_reset();
        wr_en = 1'b1; wr_data = 8'hAA;
        step();
        wr_data = 8'hBB;
        step();
        wr_data = 8'hCC;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < 13; i++) step();
        chk("t4_line_bit2", {31'd0, tx}, 32'd0);
        chk("t4_empty_pre", {31'd0, empty}, 32'd0);
        reset = 1'b1;
        #1;
        chk("t4_line_rst", {31'd0, tx}, 32'd1);
        chk("t4_empty_rst", {31'd0, empty}, 32'd1);
        chk("t4_busy_rst", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t4_line_quiet", {31'd0, tx}, 32'd1);
            chk("t4_busy_quiet", {31'd0, busy}, 32'd0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; wr_en = 1'b1; wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        chk("t4_first_wr_accepted", {31'd0, empty}, 32'd0);

        // Write at full on the edge where STOP ends and pops
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'h80 + i);
            step();
        end
        wr_en = 1'b0;
        chk("t5_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 36; i++) step();
        chk("t5_full_pre", {31'd0, full}, 32'd1);
        chk("t5_ovf_pre", {31'd0, overflow}, 32'd0);
        wr_en = 1'b1; wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        chk("t5_ovf", {31'd0, overflow}, 32'd1);
        chk("t5_full_post", {31'd0, full}, 32'd0);
        chk("t5_empty_post", {31'd0, empty}, 32'd0);
        chk("t5_busy_post", {31'd0, busy}, 32'd1);
        chk("t5_line_stop", {31'd0, tx}, 32'd1);
        step();
        chk("t5_line_next_start", {31'd0, tx}, 32'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0
        do_reset();
        wr_en = 1'b1; wr_data = 8'h07;
        step();
        wr_en = 1'b0;
        step();
        step();
        expect_frame(8'h07, 0, 1'b0);
        wr_en = 1'b1; wr_data = 8'h03;
        step();
        wr_en = 1'b0;
        step();
        step();
        expect_frame(8'h03, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_responder.md
UART_TX_RESPONDER -- requirements
Module: uart_tx_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of queued bytes; power of two, 2..64.
REQ-003 SHALL have port CLK100MHZ  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have port wr_en  in  1  CPU store strobe to the TX data register, one byte per cycle.
REQ-006 SHALL have port wr_data  in  8  byte to transmit.
REQ-007 SHALL have port clr_ovf  in  1  clears the overflow flag.
REQ-008 SHALL have port full  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-009 SHALL have port empty  out  1  FIFO holds 0 bytes.
REQ-010 SHALL have port busy  out  1  FSM is not in IDLE.
REQ-011 SHALL have port overflow  out  1  sticky flag; a write was dropped.
REQ-012 SHALL have port uart_rxd_out  out  1  serial line; idles high.

Function
REQ-013 SHALL accept a byte on any rising edge with wr_en=1 and full=0, where full is the value before that edge.
REQ-014 SHALL drop the byte on a rising edge with wr_en=1 and full=1, set overflow on that same edge and leave the FIFO contents unchanged.
REQ-015 SHALL clear overflow on an edge with clr_ovf=1; if clr_ovf=1 coincides with a dropped write, overflow SHALL remain set.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR (PAR only when the parity feature is built in) and STOP.
REQ-017 In IDLE with empty=0, the FSM SHALL pop the FIFO head into a shift register and enter START on the same edge.
REQ-018 SHALL register uart_rxd_out: 0 in START, shift-register bit 0 (LSB first) in DATA, and 1 in STOP and IDLE.
REQ-019 Each of START, DATA, PAR and STOP SHALL hold one bit for exactly CLKS_PER_BIT cycles, counted by a baud counter that runs 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
REQ-020 DATA SHALL send 8 bits, counted 0..7 by a bit counter; the FSM SHALL leave DATA after bit 7.
REQ-021 At the end of STOP, the FSM SHALL pop the next byte and enter START directly if empty=0, giving back-to-back frames with no idle gap; otherwise it SHALL enter IDLE.
REQ-022 Latency: for a byte written into an empty FIFO while the FSM is in IDLE, uart_rxd_out SHALL fall on the second rising edge after the accepting edge.
REQ-023 A simultaneous write and pop SHALL be legal: the count is unchanged, and full/empty reflect the post-edge count.
REQ-024 A write to an empty FIFO on the same edge as an IDLE check SHALL be popped on the next edge, never in the same cycle.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL have log2(FIFO_DEPTH)+1 bits.
REQ-026 busy SHALL be 1 from the edge entering START until the edge entering IDLE.

Reset
REQ-027 Asserting reset SHALL immediately set: FSM=IDLE, uart_rxd_out=1, all counters and pointers=0, empty=1, full=0, busy=0, overflow=0.
REQ-028 Reset mid-frame SHALL abort the frame and discard all queued bytes; the line SHALL return high without completing a stop bit.
REQ-029 After deassertion, the first wr_en SHALL be accepted on the first rising edge.

Configuration
REQ-030 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PAR bit between DATA and STOP equal to the XOR of the 8 data bits (even parity), making an 11-bit frame.
REQ-031 Without UART_TX_PARITY_EN, the PAR state and its logic SHALL be absent and the frame SHALL be 10 bits (8N1).

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the default CLKS_PER_BIT constant, shared with the existing UART receive path.
REQ-033 SHALL contain one sub-module, uart_tx_fifo (synchronous FIFO with push/pop/full/empty); the FSM, baud counter and shift register SHALL live in the top.

Verification (benches use CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Write 0x55 at cycle 10 -> line low at cycle 12 for 4 cycles, bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high; busy drops after 40 cycles of frame.
REQ-035 Write 0xA5,0x3C,0xFF,0x00 in 4 consecutive cycles -> 4 back-to-back frames, no high gap between the stop bit and the next start bit; empty=1 at the end.
REQ-036 Write 5 bytes in consecutive cycles while idle -> first byte popped and FIFO then fills; a 6th write at full -> overflow=1, that byte never sent; clr_ovf -> overflow=0.
REQ-037 Assert reset at cycle 3 of DATA bit 2 with 2 bytes queued -> line=1 and empty=1 immediately, no further frames.
REQ-038 With UART_TX_PARITY_EN, write 0x07 -> parity bit 1 after bit 7; write 0x03 -> parity bit 0; frame is 44 cycles.
REQ-039 At full, assert wr_en on the edge where STOP ends and pops -> write dropped (full sampled pre-edge), overflow=1, count stays FIFO_DEPTH-1.
